apb_initiator_bridge: RTL and testbench
=======================================

Name: apb_initiator_bridge

Overview:
- Converts the core/debug-side req/gnt/rvalid memory protocol into single APB4 master transfers that drive the peripheral bus node's slave port.
- Provides the initiator end of the APB links that the peripheral bus fans out to UART, GPIO, SPI, timer, event unit and the other peripherals.
- Supports one outstanding transfer at a time.
- Adds a PREADY timeout so that a hung peripheral cannot stall the core.

Parameters:
APB_ADDR_WIDTH, 32, address width of addr_i and paddr_o
APB_DATA_WIDTH, 32, data width; must be 32
TIMEOUT_CYCLES, 256, maximum ACCESS-phase cycles waiting for pready_i; 0 disables the timeout
ERR_RDATA, 32'hBADC0DE0, rdata_o value returned on timeout

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
req_i  in  1  transfer request
addr_i  in  APB_ADDR_WIDTH  byte address
we_i  in  1  1 = write
be_i  in  4  byte enables
wdata_i  in  32  write data
gnt_o  out  1  request accepted this cycle
rvalid_o  out  1  response valid, one-cycle pulse
rdata_o  out  32  read data
err_o  out  1  slave error or timeout, qualified by rvalid_o
paddr_o  out  APB_ADDR_WIDTH  APB address
pwdata_o  out  32  APB write data
pwrite_o  out  1  APB direction
psel_o  out  1  APB select
penable_o  out  1  APB enable
pstrb_o  out  4  APB write strobes
prdata_i  in  32  APB read data
pready_i  in  1  APB ready
pslverr_i  in  1  APB slave error

Behaviour:
- Clock is clk_i. Reset is synchronous and active-high on rst_i.
- FSM states are IDLE, SETUP, ACCESS and RESP. The reset state is IDLE.
- Reset values are 0 for every output, the timeout counter and all captured registers.
- IDLE:
  - gnt_o = req_i (combinational; asserted only in IDLE).
  - When req_i=1, capture the transfer on the clock edge:
    - paddr = {addr_i[AW-1:2], 2'b00}
    - pwrite = we_i
    - pwdata = wdata_i
    - pstrb = we_i ? be_i : 4'b0000
  - Then go to SETUP.
- SETUP:
  - psel_o=1, penable_o=0.
  - pready_i and pslverr_i are ignored.
  - Always go to ACCESS next cycle.
  - Clear the timeout counter.
- ACCESS:
  - psel_o=1, penable_o=1.
  - paddr_o, pwrite_o, pwdata_o and pstrb_o are held stable from SETUP through the end of ACCESS.
  - pready_i=1: latch rdata = pwrite ? 0 : prdata_i and err = pslverr_i, then go to RESP.
  - pready_i=0: increment the counter. If TIMEOUT_CYCLES != 0 and the counter reaches TIMEOUT_CYCLES-1, latch err=1 and rdata=ERR_RDATA (0 for writes), then go to RESP.
  - pready_i wins if it arrives on the same cycle the counter expires.
- RESP:
  - psel_o=0, penable_o=0.
  - rvalid_o=1 for exactly one cycle, with rdata_o and err_o valid.
  - gnt_o=0 in this state.
  - Return to IDLE.
- rdata_o and err_o hold their value until the next RESP. Only their values during rvalid_o are meaningful.
- Latency:
  - Minimum is gnt_o at cycle N, psel_o at N+1, penable_o at N+2, and rvalid_o at N+3 if pready_i is high at N+2.
  - Maximum throughput is one transfer per 4 cycles.
- The bridge never drops or reorders transfers. Exactly one rvalid_o follows each gnt_o, except when rst_i intervenes.
- Reset mid-transfer:
  - psel_o and penable_o drop on the reset edge.
  - No rvalid_o is issued for the aborted transfer. The requester must reissue it.
- addr_i[1:0] is ignored (no misaligned support). be_i is passed to pstrb_o for writes only.
- req_i changing while not in IDLE has no effect.

Test Plan:
- Read with pready_i=1 in the first ACCESS cycle, prdata_i=32'h1234_5678, addr_i=32'h1A10_0004 -> paddr_o=32'h1A10_0004, rvalid_o exactly 3 cycles after gnt_o, rdata_o=32'h1234_5678, err_o=0.
- Write of wdata_i=32'hCAFE_F00D with be_i=4'b0011, pready_i delayed 5 cycles -> psel_o/penable_o/paddr_o/pwdata_o stable for all 6 ACCESS cycles, pstrb_o=4'b0011, one rvalid_o pulse with err_o=0 and rdata_o=0.
- Read with pready_i held low and TIMEOUT_CYCLES=16 -> rvalid_o one cycle after the 16th ACCESS cycle, err_o=1, rdata_o=32'hBADC0DE0, psel_o=0 afterwards.
- pslverr_i=1 together with pready_i=1 on a read -> err_o=1 with rvalid_o, and rdata_o=prdata_i.
- req_i held high continuously for 3 reads -> gnt_o pulses at cycles 0, 4 and 8 and never in SETUP, ACCESS or RESP; 3 rvalid_o pulses in order.
- rst_i asserted for 1 cycle during ACCESS -> psel_o=0 on the next cycle and no rvalid_o; a new req_i is granted in the first IDLE cycle after reset.

Source files
------------

// File: rtl/apb_initiator_bridge.sv
// apb_initiator_bridge: req/gnt/rvalid to single APB4 master transfers with PREADY timeout
module apb_initiator_bridge #(
  parameter int          APB_ADDR_WIDTH = 32,
  parameter int          APB_DATA_WIDTH = 32,
  parameter int          TIMEOUT_CYCLES = 256,
  parameter logic [31:0] ERR_RDATA      = 32'hBADC0DE0
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      req_i,
  input  logic [APB_ADDR_WIDTH-1:0] addr_i,
  input  logic                      we_i,
  input  logic [3:0]                be_i,
  input  logic [APB_DATA_WIDTH-1:0] wdata_i,
  output logic                      gnt_o,
  output logic                      rvalid_o,
  output logic [APB_DATA_WIDTH-1:0] rdata_o,
  output logic                      err_o,
  output logic [APB_ADDR_WIDTH-1:0] paddr_o,
  output logic [APB_DATA_WIDTH-1:0] pwdata_o,
  output logic                      pwrite_o,
  output logic                      psel_o,
  output logic                      penable_o,
  output logic [3:0]                pstrb_o,
  input  logic [APB_DATA_WIDTH-1:0] prdata_i,
  input  logic                      pready_i,
  input  logic                      pslverr_i
);
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic expired;
  assign expired = (TIMEOUT_CYCLES != 0) && (cnt == CNT_MAX);
  assign gnt_o = req_i && state == IDLE && !rst_i;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= '0;
      paddr_o   <= '0;
      pwdata_o  <= '0;
      pwrite_o  <= 1'b0;
      pstrb_o   <= '0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_i) begin
          paddr_o  <= addr_i & ~APB_ADDR_WIDTH'(3);
          pwrite_o <= we_i;
          pwdata_o <= wdata_i;
          pstrb_o  <= we_i ? be_i : 4'b0000;
          psel_o   <= 1'b1;
          state    <= SETUP;
        end
        SETUP: begin
          penable_o <= 1'b1;
          cnt       <= '0;
          state     <= ACCESS;
        end
        ACCESS: if (pready_i || expired) begin
          psel_o    <= 1'b0;
          penable_o <= 1'b0;
          rvalid_o  <= 1'b1;
          err_o     <= pready_i ? pslverr_i : 1'b1;
          rdata_o   <= pwrite_o ? '0 : pready_i ? prdata_i : APB_DATA_WIDTH'(ERR_RDATA);
          state     <= RESP;
        end else begin
          cnt <= cnt + 1'b1;
        end
        RESP: begin
          rvalid_o <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_initiator_bridge.sv
// tb_apb_initiator_bridge: directed and random checks against a transaction-level model
module tb_apb_initiator_bridge;
  localparam int TO = 16;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, req, we, gnt, rvalid, err, pwrite, psel, penable, pready, pslverr;
  logic [31:0] addr, wdata, rdata, paddr, pwdata, prdata;
  logic [3:0] be, pstrb;
  int n_tests = 0;
  int n_fail = 0;
  apb_initiator_bridge #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_i(rst), .req_i(req), .addr_i(addr), .we_i(we), .be_i(be),
    .wdata_i(wdata), .gnt_o(gnt), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .paddr_o(paddr), .pwdata_o(pwdata), .pwrite_o(pwrite), .psel_o(psel),
    .penable_o(penable), .pstrb_o(pstrb), .prdata_i(prdata), .pready_i(pready),
    .pslverr_i(pslverr)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  int m_age = 0;
  bit m_resp = 0;
  logic [31:0] m_addr = 0, m_wdata = 0, m_rdata = 0;
  logic m_we = 0, m_err = 0;
  logic [3:0] m_strb = 0;
  always @(negedge clk) begin
    chk("m_gnt", gnt, m_age == 0 && !m_resp && req && !rst);
    chk("m_psel", psel, m_age >= 1);
    chk("m_penable", penable, m_age >= 2);
    chk("m_rvalid", rvalid, m_resp);
    chk("m_paddr", paddr, m_addr);
    chk("m_pwdata", pwdata, m_wdata);
    chk("m_pwrite", pwrite, m_we);
    chk("m_pstrb", pstrb, m_strb);
    chk("m_rdata", rdata, m_rdata);
    chk("m_err", err, m_err);
    if (rst) begin
      m_age = 0; m_resp = 0; m_addr = 0; m_wdata = 0; m_we = 0; m_strb = 0; m_rdata = 0; m_err = 0;
    end else if (m_resp) m_resp = 0;
    else if (m_age == 0) begin
      if (req) begin
        m_addr = {addr[31:2], 2'b00}; m_we = we; m_wdata = wdata; m_strb = we ? be : 4'b0000; m_age = 1;
      end
    end else if (m_age == 1) m_age = 2;
    else if (pready) begin
      m_rdata = m_we ? 32'h0 : prdata; m_err = pslverr; m_age = 0; m_resp = 1;
    end else if (m_age - 1 == TO) begin
      m_rdata = m_we ? 32'h0 : 32'hBADC0DE0; m_err = 1; m_age = 0; m_resp = 1;
    end else m_age++;
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    int acc, nrv;
    logic [11:0] gmask, rmask;
    rst = 1; req = 0; we = 0; addr = 0; wdata = 0; be = 0; prdata = 0; pready = 0; pslverr = 0;
    repeat (3) cyc();
    rst = 0;
    #1;
    chk("rst_psel", psel, 0); chk("rst_rvalid", rvalid, 0); chk("rst_rdata", rdata, 0);
    chk("rst_paddr", paddr, 0); chk("rst_gnt", gnt, 0);
    cyc(); req = 1; addr = 32'h1A10_0004; we = 0; be = 4'hF; #1;
    chk("t1_gnt", gnt, 1);
    cyc(); req = 0; #1;
    chk("t1_setup", {psel, penable}, 2'b10); chk("t1_gnt_setup", gnt, 0);
    cyc(); pready = 1; prdata = 32'h1234_5678; #1;
    chk("t1_access", {psel, penable}, 2'b11); chk("t1_paddr", paddr, 32'h1A10_0004);
    cyc(); pready = 0; #1;
    chk("t1_rvalid", rvalid, 1); chk("t1_rdata", rdata, 32'h1234_5678); chk("t1_err", err, 0);
    cyc();
    chk("t1_rvalid_pulse", rvalid, 0);
    cyc(); req = 1; we = 1; addr = 32'h1A10_1007; wdata = 32'hCAFE_F00D; be = 4'b0011; #1;
    chk("t2_gnt", gnt, 1);
    cyc(); req = 0; wdata = 0; be = 0;
    cyc();
    for (int i = 1; i <= 6; i++) begin
      pready = (i == 6); prdata = $urandom; #1;
      chk("t2_access", {psel, penable}, 2'b11); chk("t2_paddr", paddr, 32'h1A10_1004);
      chk("t2_pwdata", pwdata, 32'hCAFE_F00D); chk("t2_pstrb", pstrb, 4'b0011);
      cyc();
    end
    pready = 0;
    chk("t2_rvalid", rvalid, 1); chk("t2_rdata", rdata, 0); chk("t2_err", err, 0);
    cyc(); req = 1; we = 0; addr = 32'h1A10_2000; #1;
    chk("t3_gnt", gnt, 1);
    cyc(); req = 0;
    cyc();
    acc = 0;
    while (!rvalid && acc < 40) begin
      if (penable) acc++;
      cyc();
    end
    chk("t3_access_cycles", acc, TO); chk("t3_rvalid", rvalid, 1);
    chk("t3_err", err, 1); chk("t3_rdata", rdata, 32'hBADC0DE0); chk("t3_psel", psel, 0);
    cyc();
    chk("t3_after", {psel, rvalid}, 2'b00);
    cyc(); req = 1; we = 0; addr = 32'h1A10_3008; #1;
    cyc(); req = 0;
    cyc(); pready = 1; pslverr = 1; prdata = 32'hDEAD_BEEF;
    cyc(); pready = 0; pslverr = 0; #1;
    chk("t4_rvalid", rvalid, 1); chk("t4_err", err, 1); chk("t4_rdata", rdata, 32'hDEAD_BEEF);
    cyc(); pready = 1; gmask = 0; rmask = 0;
    for (int c = 0; c < 12; c++) begin
      req = (c <= 8); we = 0; addr = 32'h1A10_0000 + 32'(c * 16); prdata = $urandom; #1;
      gmask[c] = gnt; rmask[c] = rvalid;
      cyc();
    end
    req = 0; pready = 0;
    chk("t5_gnt_cycles", gmask, 12'h111); chk("t5_rvalid_cycles", rmask, 12'h888);
    cyc(); req = 1; addr = 32'h1A10_4000; #1;
    cyc(); req = 0;
    cyc();
    cyc(); rst = 1;
    cyc(); rst = 0; req = 1; pready = 1; #1;
    chk("t6_psel", {psel, penable}, 2'b00); chk("t6_gnt", gnt, 1); chk("t6_rvalid", rvalid, 0);
    nrv = 0;
    for (int c = 0; c < 6; c++) begin
      cyc(); req = 0; #1;
      if (rvalid) nrv++;
    end
    chk("t6_rvalid_count", nrv, 1);
    pready = 0;
    for (int i = 0; i < 600; i++) begin
      cyc();
      rst = ($urandom_range(0, 99) == 0);
      req = $urandom_range(0, 1); we = $urandom_range(0, 1); addr = $urandom; be = 4'($urandom);
      wdata = $urandom; prdata = $urandom; pslverr = ($urandom_range(0, 3) == 0);
      pready = (i % 150) < 30 ? 1'b0 : ($urandom_range(0, 3) == 0);
    end
    cyc(); rst = 0; req = 0; pready = 1;
    repeat (4) cyc();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
